// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants and types for the front-panel button conditioner
//
// Purpose : window-position encodings, default debounce length, the
//           arbitrated button-event type and the debounce counter width helper.
// Ports   : none (package).
package btn_pkg;

    // Display window positions (which three digits are shown).
    localparam logic [1:0] WIN_HI  = 2'd0;   // d0..d2
    localparam logic [1:0] WIN_MID = 2'd1;   // d1..d3
    localparam logic [1:0] WIN_LO  = 2'd2;   // d2..d4

    // 10 ms at 100 MHz.
    localparam int DEB_CYCLES_DEFAULT = 1000000;

    // Outcome of priority arbitration between simultaneous press events.
    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_SL    = 2'd2,
        EV_SR    = 2'd3
    } btn_ev_e;

    // Counter must reach DEB_CYCLES-1; $clog2(DEB_CYCLES) bits cover that.
    // Clamped to one bit so a degenerate DEB_CYCLES of 1 still elaborates.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debounce counter and press detector for one button
//
// Purpose : brings a raw asynchronous button into the clock domain, accepts a
//           level change only after DEB_CYCLES consecutive differing samples,
//           and flags the released-to-pressed transition.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset
//           i_btn    - raw button, active-high, asynchronous
//           o_press  - high during the cycle whose rising edge accepts a press;
//                      unregistered so the parent can act on that same edge
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    logic w_differ;
    logic w_expire;

    assign w_differ = r_sync2 ^ r_stable;
    // The flip happens on the edge where the counter already shows DEB_CYCLES-1
    // and the input still disagrees, i.e. the DEB_CYCLES-th differing sample.
    assign w_expire = w_differ && (r_cnt == CNT_LAST);
    // Only a flip from released (0) to pressed (1) is a press.
    assign o_press  = w_expire && !r_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!w_differ || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_expire) begin
                r_stable <= ~r_stable;
            end
        end
    end

endmodule

// File: rtl/btn_ctrl.sv
// rtl/btn_ctrl.sv - front-panel conditioner: debounced pulses, operand latch, window position
//
// Purpose : turns the start / shift-left / shift-right buttons into one-cycle
//           pulses (start > SR > SL when presses coincide), latches the two
//           signed operands from the switches on start, and tracks the
//           display window position (0..2, saturating).
// Ports   : clk, rst_n              - clock, asynchronous active-low reset
//           btn_start/btn_sl/btn_sr - raw buttons, active-high
//           sw[15:8]/sw[7:0]        - operand A / operand B switches
//           start_p/sl_p/sr_p       - registered one-cycle pulses
//           op_a/op_b               - operands latched on start
//           win_pos                 - display window position
module btn_ctrl
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_sl,
    input  logic        btn_sr,
    input  logic [15:0] sw,
    output logic        start_p,
    output logic        sl_p,
    output logic        sr_p,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [1:0]  win_pos
);

    logic    w_press_start;
    logic    w_press_sl;
    logic    w_press_sr;
    btn_ev_e w_ev;

    logic       r_start_p;
    logic       r_sl_p;
    logic       r_sr_p;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic [1:0] r_win_pos;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_start),
        .o_press (w_press_start)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_sl),
        .o_press (w_press_sl)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_sr),
        .o_press (w_press_sr)
    );

    // Losing presses are dropped outright, never queued for a later cycle.
    always_comb begin
        w_ev = EV_NONE;
        if (w_press_start) begin
            w_ev = EV_START;
        end else if (w_press_sr) begin
            w_ev = EV_SR;
        end else if (w_press_sl) begin
            w_ev = EV_SL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_p <= 1'b0;
            r_sl_p    <= 1'b0;
            r_sr_p    <= 1'b0;
            r_op_a    <= 8'h00;
            r_op_b    <= 8'h00;
            r_win_pos <= WIN_MID;
        end else begin
            r_start_p <= (w_ev == EV_START);
            r_sl_p    <= (w_ev == EV_SL);
            r_sr_p    <= (w_ev == EV_SR);
            case (w_ev)
                EV_START: begin
                    r_op_a    <= sw[15:8];
                    r_op_b    <= sw[7:0];
                    r_win_pos <= WIN_MID;
                end
                EV_SL: begin
                    // Saturates at WIN_LO; the pulse still fires.
                    if (r_win_pos != WIN_LO) begin
                        r_win_pos <= r_win_pos + 2'd1;
                    end
                end
                EV_SR: begin
                    if (r_win_pos != WIN_HI) begin
                        r_win_pos <= r_win_pos - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign start_p = r_start_p;
    assign sl_p    = r_sl_p;
    assign sr_p    = r_sr_p;
    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign win_pos = r_win_pos;

endmodule

// File: tb/tb_btn_ctrl.sv
// tb/tb_btn_ctrl.sv - self-checking bench for btn_ctrl with a pulse scoreboard
module tb_btn_ctrl;

    localparam int DEB = 4;
    localparam int LAT = DEB + 2;
    localparam int K_START = 0;
    localparam int K_SL    = 1;
    localparam int K_SR    = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] win;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        btn_start;
    logic        btn_sl;
    logic        btn_sr;
    logic [15:0] sw;
    logic        start_p;
    logic        sl_p;
    logic        sr_p;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [1:0]  win_pos;

    int   total;
    int   bad;
    int   cyc;
    exp_t sb[$];

    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [1:0] m_win;

    btn_ctrl #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .btn_sl    (btn_sl),
        .btn_sr    (btn_sr),
        .sw        (sw),
        .start_p   (start_p),
        .sl_p      (sl_p),
        .sr_p      (sr_p),
        .op_a      (op_a),
        .op_b      (op_b),
        .win_pos   (win_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.a    = m_a;
        e.b    = m_b;
        e.win  = m_win;
        sb.push_back(e);
    endtask

    // One clean press: held 10 cycles, released 10 cycles; model updated first.
    task automatic press(input int kind);
        case (kind)
            K_START: begin m_a = sw[15:8]; m_b = sw[7:0]; m_win = 2'd1; end
            K_SL:    m_win = (m_win == 2'd2) ? 2'd2 : m_win + 2'd1;
            default: m_win = (m_win == 2'd0) ? 2'd0 : m_win - 2'd1;
        endcase
        push_exp(kind, cyc + LAT);
        case (kind)
            K_START: btn_start = 1'b1;
            K_SL:    btn_sl    = 1'b1;
            default: btn_sr    = 1'b1;
        endcase
        tick(10);
        btn_start = 1'b0;
        btn_sl    = 1'b0;
        btn_sr    = 1'b0;
        tick(10);
    endtask

    // Scoreboard consumer: every pulse pops one expected event.
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && (start_p || sl_p || sr_p)) begin
            check("pulse_onehot", int'(start_p) + int'(sl_p) + int'(sr_p), 1);
            mon_kind = start_p ? K_START : (sl_p ? K_SL : K_SR);
            if (sb.size() == 0) begin
                check("unexpected_pulse_kind", mon_kind, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_op_a", op_a, mon_e.a);
                check("pulse_op_b", op_b, mon_e.b);
                check("pulse_win_pos", win_pos, mon_e.win);
            end
        end
    end

    initial begin
        int t1;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_sl    = 1'b0;
        btn_sr    = 1'b0;
        sw        = 16'h0000;
        m_a       = 8'h00;
        m_b       = 8'h00;
        m_win     = 2'd1;

        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("idle_start_p", start_p, 0);
        check("idle_sl_p", sl_p, 0);
        check("idle_sr_p", sr_p, 0);
        check("idle_op_a", op_a, 8'h00);
        check("idle_op_b", op_b, 8'h00);
        check("idle_win_pos", win_pos, 2'd1);

        sw = 16'hF905;
        press(K_START);

        press(K_SL);
        press(K_SL);
        press(K_SL);
        press(K_SR);
        press(K_SR);
        press(K_SR);

        // Glitch of 3 synchronized cycles is one short of acceptance.
        btn_sr = 1'b1;
        tick(3);
        btn_sr = 1'b0;
        tick(12);
        check("glitch_win_pos", win_pos, 2'd0);
        check("glitch_sb_empty", sb.size(), 0);

        // Coincident presses: only start is honoured.
        sw    = 16'h7F80;
        m_a   = 8'h7F;
        m_b   = 8'h80;
        m_win = 2'd1;
        push_exp(K_START, cyc + LAT);
        btn_start = 1'b1;
        btn_sl    = 1'b1;
        btn_sr    = 1'b1;
        tick(10);
        btn_start = 1'b0;
        btn_sl    = 1'b0;
        btn_sr    = 1'b0;
        tick(10);
        check("coincide_win_pos", win_pos, 2'd1);
        press(K_SL);
        press(K_SR);

        // Reset mid-debounce with the button held through release.
        btn_sl = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        check("midrst_op_a", op_a, 8'h00);
        check("midrst_win_pos", win_pos, 2'd1);
        tick(2);
        rst_n = 1'b1;
        t1    = cyc;
        m_a   = 8'h00;
        m_b   = 8'h00;
        m_win = 2'd2;
        push_exp(K_SL, t1 + LAT);
        tick(10);
        btn_sl = 1'b0;
        tick(12);
        check("final_win_pos", win_pos, 2'd2);
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_ctrl.md
# btn_ctrl

Front-panel input conditioner that feeds the multiplier and the 7-segment display controller. It synchronizes and debounces three push-buttons (start, shift-left, shift-right) into single-cycle pulses, latches the two signed 8-bit operands from the switches on start, and tracks the display window position. Its pulse outputs drive the display controller's start/SL/SR inputs.

## Interface
Parameters:
- DEB_CYCLES, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_sl  in  1  raw shift-left button, asynchronous, active-high.
- btn_sr  in  1  raw shift-right button, asynchronous, active-high.
- sw  in  16  operand switches; sw[15:8] = operand A, sw[7:0] = operand B, two's complement.
- start_p  out  1  one-cycle start pulse.
- sl_p  out  1  one-cycle shift-left pulse.
- sr_p  out  1  one-cycle shift-right pulse.
- op_a  out  8  latched operand A.
- op_b  out  8  latched operand B.
- win_pos  out  2  display window: 0 = digits d0..d2, 1 = d1..d3, 2 = d2..d4.

## Operation
- Each button: 2-flop synchronizer -> debouncer -> rising-edge detector.
- Debouncer holds a stable level (reset 0). Counter clears whenever synchronized input equals stable level; otherwise increments. When count reaches DEB_CYCLES-1 with input still differing, stable level flips and counter clears.
- Released-to-pressed transition of stable level = press event. Pressed-to-released produces nothing.
- Simultaneous press events in one cycle: only the highest priority is honoured, priority start > SR > SL; lower ones are discarded (no deferred pulse).
- Start event: start_p = 1; op_a <= sw[15:8], op_b <= sw[7:0] on same edge; win_pos <= 1.
- SL event: sl_p = 1; win_pos <= min(win_pos+1, 2). Pulse fires even when saturated.
- SR event: sr_p = 1; win_pos <= max(win_pos-1, 0). Pulse fires even when saturated.
- win_pos value 3 never produced.
- op_a/op_b change only on a start event; sw is sampled directly (operator holds switches steady before pressing).
- Reset values: start_p, sl_p, sr_p = 0; op_a, op_b = 0; win_pos = 1; all stable levels and counters 0.
- Reset mid-debounce discards progress. A button held through reset release is seen as a new press and yields one pulse after debounce.

## Timing
- Raw button rising at cycle 0 and held: synchronizer output high at cycle 2; pulse asserted at cycle DEB_CYCLES+2, high for exactly one cycle.
- op_a/op_b/win_pos updated on the same edge that raises the corresponding pulse (visible the cycle the pulse is high).
- A glitch shorter than DEB_CYCLES synchronized cycles produces no pulse.
- Minimum press-to-press spacing: 2*DEB_CYCLES cycles (release must also debounce).
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package btn_pkg: WIN_HI = 2'd0, WIN_MID = 2'd1, WIN_LO = 2'd2; DEB_CYCLES_DEFAULT = 1000000; counter width derived as $clog2(DEB_CYCLES).
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse, parameter DEB_CYCLES), instantiated three times. Top holds priority arbitration, operand latch and win_pos saturating counter.

## Test plan
Bench uses DEB_CYCLES = 4.
- Reset, then idle 20 cycles -> all pulses 0, op_a = op_b = 0, win_pos = 1.
- sw = 16'hF905, btn_start high for 10 cycles from cycle 0 -> start_p high exactly at cycle 6, op_a = 8'hF9 (-7), op_b = 8'h05; no second pulse on release.
- btn_sl pulsed 3 times (each held 10, released 10) -> three sl_p pulses; win_pos 1 -> 2 -> 2 -> 2. Then 3 SR presses -> win_pos 1 -> 0 -> 0.
- btn_sr high for 3 cycles only -> no sr_p, win_pos unchanged.
- btn_start and btn_sr and btn_sl rise on the same cycle -> only start_p fires, win_pos = 1; sr/sl released and re-pressed later -> sr_p/sl_p fire normally.
- btn_sl held; rst_n low for 2 cycles during debounce, released with button still held -> exactly one sl_p at DEB_CYCLES+2 cycles after rst_n rise (synchronizer refill), win_pos = 2.
